// File: rtl/execute_cycle_pkg.sv
// Shared RV32 EX-stage definitions: ALU op codes, RV32M funct3 encodings,
// forwarding selects, divider FSM states and the operand-forwarding helper.
// Combinational only; carries no flow control of its own.
package riscv_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Any select other than WB/MEM (including 11) reads the register file.
    function automatic logic [31:0] fwd_sel(input logic [1:0] sel,
                                            input logic [31:0] rf,
                                            input logic [31:0] wb,
                                            input logic [31:0] mem);
        logic [31:0] v;
        case (sel)
            FWD_WB:  v = wb;
            FWD_MEM: v = mem;
            default: v = rf;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/execute_cycle_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage bundled as one bus.
// No latency of its own; slave = EX stage, master = pipeline/testbench.
// Backpressure travels as StallE (slave -> master) to freeze the front end.
interface execute_cycle_if;
    // ID/EX side
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic        MulDivE;
    logic [2:0]  MulDivOpE;
    logic [31:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    // EX results / EX/MEM register
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RD_M;

    modport master (
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
               ALUControlE, MulDivE, MulDivOpE, RD1_E, RD2_E, ImmExtE, PCE,
               PCPlus4E, RD_E, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
               ALU_ResultM, WriteDataM, PCPlus4M, RD_M
    );

    modport slave (
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
               ALUControlE, MulDivE, MulDivOpE, RD1_E, RD2_E, ImmExtE, PCE,
               PCPlus4E, RD_E, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, StallE, RegWriteM, MemWriteM, ResultSrcM,
               ALU_ResultM, WriteDataM, PCPlus4M, RD_M
    );
endinterface

// File: rtl/execute_cycle_div_unit.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Latency: special cases (x/0, MIN/-1) same cycle; otherwise 1 + DIV_ITERS + 1 cycles.
// Backpressure: busy is high from start until the DONE cycle; caller holds inputs.
// Ports: clk, rst (async active-low), start/op/dividend/divisor in;
//        busy, done, result (valid in DONE), bypass_result (special cases) out.
module div_unit
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] bypass_result
);
    localparam int              CNT_W   = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(DIV_ITERS - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  quo, rem, dsr;
    logic             q_neg, r_neg, want_rem;

    logic             is_signed, rem_op, div_zero, overflow, special;
    logic             a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag, rem_step, q_fix, r_fix;
    logic [XLEN:0]    trial;
    logic             ge;

    assign is_signed = (op == MD_DIV) || (op == MD_REM);
    assign rem_op    = (op == MD_REM) || (op == MD_REMU);
    assign div_zero  = (divisor == '0);
    assign overflow  = is_signed && (dividend == MIN_NEG) && (divisor == '1);
    assign special   = div_zero || overflow;

    always_comb begin
        bypass_result = '0;
        if (div_zero)
            bypass_result = rem_op ? dividend : '1;
        else if (overflow)
            bypass_result = rem_op ? '0 : MIN_NEG;
    end

    assign a_neg = is_signed & dividend[XLEN-1];
    assign b_neg = is_signed & divisor[XLEN-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor  : divisor;

    // Partial remainder stays below the divisor, so XLEN+1 bits hold the shifted trial.
    assign trial    = {rem, quo[XLEN-1]};
    assign ge       = trial >= {1'b0, dsr};
    assign rem_step = ge ? (trial[XLEN-1:0] - dsr) : trial[XLEN-1:0];

    assign q_fix = q_neg ? -quo : quo;
    assign r_fix = r_neg ? -rem : rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DIV_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start && !special) state_nxt = DIV_BUSY;
            DIV_BUSY: if (count == LAST)     state_nxt = DIV_DONE;
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    // Stall is qualified with rst so a divide sitting in EX during reset
    // does not hold the front end.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        result = rem_op ? r_fix : q_fix;
        case (state)
            DIV_IDLE: busy = rst && start && !special;
            DIV_BUSY: busy = 1'b1;
            DIV_DONE: done = 1'b1;
            default:  busy = 1'b0;
        endcase
        if (want_rem) result = r_fix;
        else          result = q_fix;
    end

    // Operands are captured at start: forwarded sources move while EX stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            quo      <= '0;
            rem      <= '0;
            dsr      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            want_rem <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: if (start && !special) begin
                    count    <= '0;
                    quo      <= a_mag;
                    rem      <= '0;
                    dsr      <= b_mag;
                    q_neg    <= a_neg ^ b_neg;
                    r_neg    <= a_neg;
                    want_rem <= rem_op;
                end
                DIV_BUSY: begin
                    quo   <= {quo[XLEN-2:0], ge};
                    rem   <= rem_step;
                    count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/execute_cycle.sv
// RV32I EX stage: forwarding muxes, ALU, branch decision, EX/MEM register, optional RV32M.
// Latency: PCSrcE/PCTargetE/StallE combinational; results registered 1 cycle (divide 34).
// Backpressure: StallE freezes PC/IF/ID/ID-EX while EX/MEM takes bubbles.
// Ports: clk, rst (async active-low), ex (execute_cycle_if.slave: ID/EX in, EX/MEM out).
// Build option EXEC_MDU_EN: adds single-cycle multiply and iterative divider; without it
// MulDivE/MulDivOpE are ignored and StallE is 0.
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic           clk,
    input  logic           rst,
    execute_cycle_if.slave ex
);
    if (XLEN != 32 || DIV_ITERS != XLEN) begin : g_bad_cfg
        $error("execute_cycle supports only XLEN=32 with DIV_ITERS=XLEN");
    end

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_res, ex_res;
    logic            zero, stall;

    assign src_a = fwd_sel(ex.ForwardAE, ex.RD1_E, ex.ResultW, ex.ALU_ResultM);
    assign fwd_b = fwd_sel(ex.ForwardBE, ex.RD2_E, ex.ResultW, ex.ALU_ResultM);
    assign src_b = ex.ALUSrcE ? ex.ImmExtE : fwd_b;

    always_comb begin
        alu_res = '0;
        case (ex.ALUControlE)
            ALU_ADD:  alu_res = src_a + src_b;
            ALU_SUB:  alu_res = src_a - src_b;
            ALU_AND:  alu_res = src_a & src_b;
            ALU_OR:   alu_res = src_a | src_b;
            ALU_XOR:  alu_res = src_a ^ src_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_SLL:  alu_res = src_a << src_b[4:0];
            ALU_SRL:  alu_res = src_a >> src_b[4:0];
            ALU_SRA:  alu_res = $unsigned($signed(src_a) >>> src_b[4:0]);
            ALU_LUI:  alu_res = src_b;
            default:  alu_res = '0;
        endcase
    end

    assign zero         = ((src_a - src_b) == '0);
    assign ex.PCSrcE    = ex.JumpE | (ex.BranchE & zero);
    assign ex.PCTargetE = ex.PCE + ex.ImmExtE;
    assign ex.StallE    = stall;

`ifdef EXEC_MDU_EN
    logic                a_sgn, b_sgn, is_div, div_start, div_done;
    logic [2*XLEN-1:0]   a_ext, b_ext, prod;
    logic [XLEN-1:0]     mul_res, div_result, div_bypass, div_out;

    // Sign/zero extension to 2*XLEN gives the same low 64 bits as a 33x33 signed product.
    assign a_sgn   = (ex.MulDivOpE == MD_MULH) || (ex.MulDivOpE == MD_MULHSU);
    assign b_sgn   = (ex.MulDivOpE == MD_MULH);
    assign a_ext   = {{XLEN{a_sgn & src_a[XLEN-1]}}, src_a};
    assign b_ext   = {{XLEN{b_sgn & src_b[XLEN-1]}}, src_b};
    assign prod    = a_ext * b_ext;
    assign mul_res = (ex.MulDivOpE == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    assign is_div    = ex.MulDivOpE inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    assign div_start = ex.MulDivE & is_div;

    div_unit #(.XLEN(XLEN), .DIV_ITERS(DIV_ITERS)) u_div (
        .clk           (clk),
        .rst           (rst),
        .start         (div_start),
        .op            (ex.MulDivOpE),
        .dividend      (src_a),
        .divisor       (src_b),
        .busy          (stall),
        .done          (div_done),
        .result        (div_result),
        .bypass_result (div_bypass)
    );

    assign div_out = div_done ? div_result : div_bypass;
    assign ex_res  = !ex.MulDivE ? alu_res : (is_div ? div_out : mul_res);
`else
    logic mdu_unused;
    assign mdu_unused = ^{ex.MulDivE, ex.MulDivOpE};
    assign stall      = 1'b0;
    assign ex_res     = alu_res;
`endif

    // While stalled only the write enables are cleared; other fields hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex.RegWriteM   <= 1'b0;
            ex.MemWriteM   <= 1'b0;
            ex.ResultSrcM  <= '0;
            ex.ALU_ResultM <= '0;
            ex.WriteDataM  <= '0;
            ex.PCPlus4M    <= '0;
            ex.RD_M        <= '0;
        end else if (stall) begin
            ex.RegWriteM   <= 1'b0;
            ex.MemWriteM   <= 1'b0;
        end else begin
            ex.RegWriteM   <= ex.RegWriteE;
            ex.MemWriteM   <= ex.MemWriteE;
            ex.ResultSrcM  <= ex.ResultSrcE;
            ex.ALU_ResultM <= ex_res;
            ex.WriteDataM  <= fwd_b;
            ex.PCPlus4M    <= ex.PCPlus4E;
            ex.RD_M        <= ex.RD_E;
        end
    end
endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed cases plus randomized ALU/forwarding
// traffic against an arithmetic reference model; RV32M cases when EXEC_MDU_EN is defined.
module tb_execute_cycle;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    execute_cycle_if bus();

    execute_cycle #(.XLEN(32), .DIV_ITERS(32)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_alu;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] rf,
                                            input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'b01) return wb;
        if (sel == 2'b10) return mem;
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return 32'($signed(a) >>> sh);
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mul_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint av, bv, p;
        av = (op == 3'd1 || op == 3'd2) ? longint'($signed(a)) : longint'({32'd0, a});
        bv = (op == 3'd1) ? longint'($signed(b)) : longint'({32'd0, b});
        p  = av * bv;
        return (op == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] div_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint q, r;
        bit sgn, want_rem;
        sgn      = (op == 3'd4 || op == 3'd6);
        want_rem = (op == 3'd6 || op == 3'd7);
        if (b == 32'd0) return want_rem ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        return want_rem ? r[31:0] : q[31:0];
    endfunction

    task automatic clear_in();
        bus.RegWriteE = 0; bus.MemWriteE = 0; bus.JumpE = 0; bus.BranchE = 0;
        bus.ALUSrcE = 0; bus.ResultSrcE = 0; bus.ALUControlE = 0; bus.MulDivE = 0;
        bus.MulDivOpE = 0; bus.RD1_E = 0; bus.RD2_E = 0; bus.ImmExtE = 0; bus.PCE = 0;
        bus.PCPlus4E = 0; bus.RD_E = 0; bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ResultW = 0;
    endtask

    // One non-stalling instruction: check combinational outputs, clock, check EX/MEM.
    task automatic step(input string tag);
        logic [31:0] a, fb, b, res, tgt, pc4;
        logic [31:0] ctl;
        logic br;
        a   = fwd_ref(bus.ForwardAE, bus.RD1_E, bus.ResultW, m_alu);
        fb  = fwd_ref(bus.ForwardBE, bus.RD2_E, bus.ResultW, m_alu);
        b   = bus.ALUSrcE ? bus.ImmExtE : fb;
        res = alu_ref(bus.ALUControlE, a, b);
`ifdef EXEC_MDU_EN
        if (bus.MulDivE) res = mul_ref(bus.MulDivOpE, a, b);
`endif
        br  = bus.JumpE | (bus.BranchE & (a == b));
        tgt = bus.PCE + bus.ImmExtE;
        pc4 = bus.PCPlus4E;
        ctl = {23'd0, bus.RegWriteE, bus.MemWriteE, bus.ResultSrcE, bus.RD_E};
        #2;
        check({tag, " pcsrc"}, {31'd0, bus.PCSrcE}, {31'd0, br});
        check({tag, " pctgt"}, bus.PCTargetE, tgt);
        check({tag, " stall"}, {31'd0, bus.StallE}, 32'd0);
        @(posedge clk); #1;
        m_alu = res;
        check({tag, " alu_m"}, bus.ALU_ResultM, res);
        check({tag, " wd_m"}, bus.WriteDataM, fb);
        check({tag, " pc4_m"}, bus.PCPlus4M, pc4);
        check({tag, " ctl_m"}, {23'd0, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RD_M}, ctl);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " alu_m"}, bus.ALU_ResultM, 32'd0);
        check({tag, " wd_m"}, bus.WriteDataM, 32'd0);
        check({tag, " pc4_m"}, bus.PCPlus4M, 32'd0);
        check({tag, " ctl_m"}, {23'd0, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.RD_M}, 32'd0);
        check({tag, " stall"}, {31'd0, bus.StallE}, 32'd0);
    endtask

`ifdef EXEC_MDU_EN
    // Issue a divide and hold it until EX lets it go; sources are scrambled during
    // the stall to show the operands were captured at start.
    task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_stalls);
        int stalls, bubble_bad;
        bit fin;
        clear_in();
        bus.RegWriteE = 1; bus.RD_E = 5'd7; bus.MulDivE = 1; bus.MulDivOpE = op;
        bus.RD1_E = a; bus.RD2_E = b;
        stalls = 0; bubble_bad = 0; fin = 0;
        for (int i = 0; i < 60 && !fin; i++) begin
            #2;
            if (bus.StallE) begin
                stalls++;
                @(posedge clk); #1;
                if (bus.RegWriteM !== 1'b0) bubble_bad++;
                bus.RD1_E = $urandom; bus.RD2_E = $urandom;
            end else begin
                @(posedge clk); #1;
                fin = 1;
            end
        end
        check({tag, " stalls"}, 32'(stalls), 32'(exp_stalls));
        check({tag, " bubble"}, 32'(bubble_bad), 32'd0);
        check({tag, " result"}, bus.ALU_ResultM, exp);
        check({tag, " rw"}, {31'd0, bus.RegWriteM}, 32'd1);
        m_alu = exp;
    endtask
`endif

    initial begin
        clear_in();
        m_alu = 0;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1;

        // Forwarding
        clear_in(); bus.RegWriteE = 1; bus.RD1_E = 3; bus.RD2_E = 4; bus.ALUControlE = ALU_ADD;
        step("seed");
        check("seed7", bus.ALU_ResultM, 32'd7);
        bus.RD1_E = 5; bus.ForwardAE = 2'b10; bus.RD2_E = 3;
        step("fwd_a");
        check("fwd_a10", bus.ALU_ResultM, 32'd10);
        bus.ForwardAE = 2'b00; bus.ForwardBE = 2'b01; bus.ResultW = 9;
        step("fwd_b");
        check("fwd_b9", bus.WriteDataM, 32'd9);

        // Branch
        clear_in(); bus.PCE = 32'h100; bus.ImmExtE = 16; bus.RD1_E = 4; bus.RD2_E = 4;
        bus.BranchE = 1; bus.ALUControlE = ALU_SUB;
        #2;
        check("br_taken", {31'd0, bus.PCSrcE}, 32'd1);
        check("br_target", bus.PCTargetE, 32'h110);
        bus.RD2_E = 5;
        #1;
        check("br_not_taken", {31'd0, bus.PCSrcE}, 32'd0);
        step("branch");

        // Randomized ALU / forwarding / control traffic
        for (int i = 0; i < 150; i++) begin
            bus.RegWriteE   = 1'($urandom);
            bus.MemWriteE   = 1'($urandom);
            bus.JumpE       = ($urandom_range(0, 7) == 0);
            bus.BranchE     = 1'($urandom);
            bus.ALUSrcE     = 1'($urandom);
            bus.ResultSrcE  = 2'($urandom);
            bus.ALUControlE = 4'($urandom_range(0, 15));
            bus.RD1_E       = $urandom;
            bus.RD2_E       = ($urandom_range(0, 3) == 0) ? bus.RD1_E : $urandom;
            bus.ImmExtE     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            bus.PCE         = $urandom;
            bus.PCPlus4E    = bus.PCE + 4;
            bus.RD_E        = 5'($urandom);
            bus.ForwardAE   = 2'($urandom_range(0, 2));
            bus.ForwardBE   = 2'($urandom_range(0, 3));
            bus.ResultW     = $urandom;
`ifdef EXEC_MDU_EN
            bus.MulDivE     = ($urandom_range(0, 3) == 0);
            bus.MulDivOpE   = 3'($urandom_range(0, 3));
            if (bus.MulDivE) bus.ALUSrcE = 0;
`else
            bus.MulDivE     = 1'($urandom);
            bus.MulDivOpE   = 3'($urandom_range(0, 7));
`endif
            step("rand");
        end

`ifdef EXEC_MDU_EN
        // Multiply
        clear_in(); bus.RegWriteE = 1; bus.MulDivE = 1; bus.MulDivOpE = MD_MUL;
        bus.RD1_E = 6; bus.RD2_E = 7;
        step("mul");
        check("mul42", bus.ALU_ResultM, 32'd42);
        bus.MulDivOpE = MD_MULH; bus.RD1_E = 32'h8000_0000; bus.RD2_E = 32'h8000_0000;
        step("mulh");
        check("mulh_min", bus.ALU_ResultM, 32'h4000_0000);
        bus.MulDivOpE = MD_MULHU; bus.RD1_E = 32'hFFFF_FFFF; bus.RD2_E = 32'hFFFF_FFFF;
        step("mulhu");
        check("mulhu_max", bus.ALU_ResultM, 32'hFFFF_FFFE);

        // Divide: signed, special cases, back-to-back
        run_div("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_div("rem_m7_2", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_div("divu_5_0", MD_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_div("remu_5_0", MD_REMU, 32'd5, 32'd0, 32'd5, 0);
        run_div("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        for (int i = 0; i < 6; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            int          st;
            op = 3'($urandom_range(4, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            st = (b == 0) ? 0 : 33;
            run_div("div_rand", op, a, b, div_ref(op, a, b), st);
        end

        // Reset in the middle of a divide
        clear_in(); bus.RegWriteE = 1; bus.MulDivE = 1; bus.MulDivOpE = MD_DIV;
        bus.RD1_E = 32'hFFFF_FFF9; bus.RD2_E = 32'd2;
        repeat (11) @(posedge clk);
        #1;
        check("pre_rst_stall", {31'd0, bus.StallE}, 32'd1);
        rst = 0;
        #2;
        check_reset_outputs("mid_rst");
        @(posedge clk); #1;
        clear_in();
        rst = 1;
        m_alu = 0;
        run_div("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd14, 33);
`else
        // Without the MDU an RV32M request is just the ALU op
        clear_in(); bus.RegWriteE = 1; bus.MulDivE = 1; bus.MulDivOpE = MD_DIV;
        bus.RD1_E = 32'hFFFF_FFF9; bus.RD2_E = 32'd2; bus.ALUControlE = ALU_ADD;
        step("nomdu");
        check("nomdu_add", bus.ALU_ResultM, 32'hFFFF_FFFB);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- EX stage of the 5-stage RV32I pipeline, directly upstream of the memory stage. It consumes ID/EX signals and produces the registered EX/MEM signals that the memory stage takes in.
- Contains:
  - operand forwarding muxes;
  - the ALU;
  - branch/jump target and decision logic;
  - the EX/MEM pipeline register;
  - an optional RV32M multiply/divide unit with a multi-cycle iterative divider that stalls the front of the pipeline.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DIV_ITERS, 32, divider iterations, one quotient bit per cycle; must equal XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  in  1 each  ID/EX control
- ResultSrcE  in  2  writeback select, passed through
- ALUControlE  in  4  ALU operation
- MulDivE  in  1  instruction is an RV32M operation
- MulDivOpE  in  3  funct3 of the RV32M instruction
- RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E  in  32 each  operands/PC
- RD_E  in  5  destination register
- ForwardAE, ForwardBE  in  2 each  00 = register file, 01 = ResultW, 10 = ALU_ResultM
- ResultW  in  32  writeback result
- PCSrcE  out  1  redirect fetch, combinational
- PCTargetE  out  32  PCE + ImmExtE, combinational
- StallE  out  1  EX busy; hazard unit freezes PC, IF/ID and ID/EX, combinational
- RegWriteM, MemWriteM  out  1 each  registered
- ResultSrcM  out  2  registered
- ALU_ResultM, WriteDataM, PCPlus4M  out  32 each  registered
- RD_M  out  5  registered

Behaviour:
- Operand selection:
  - SrcA = forwarded RD1 per ForwardAE.
  - FwdB = forwarded RD2 per ForwardBE; encoding 11 selects the register-file value.
  - SrcB = ALUSrcE ? ImmExtE : FwdB.
  - WriteData = FwdB.
- ALU op codes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt (signed), 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 pass SrcB (lui).
  - Other codes give 0.
  - Shift amount is SrcB[4:0]; arithmetic wraps modulo 2^32.
- Branch/jump:
  - ZeroE = (SrcA - SrcB) == 0.
  - PCSrcE = JumpE | (BranchE & ZeroE).
- EX/MEM register:
  - On each posedge, when StallE = 0, it loads the EX results.
  - When StallE = 1 it loads a bubble: RegWriteM = 0, MemWriteM = 0; the other fields are don't-care and are held at their previous values.
  - Async reset clears all outputs to 0.
- Multiply (MulDivOp 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU):
  - Single-cycle, from a combinational 33x33 signed product; no stall.
  - MUL returns the low word; the other three return the high word.
- Divide (100 DIV, 101 DIVU, 110 REM, 111 REMU):
  - Special cases complete in one cycle with no stall:
    - divisor 0: quotient = 0xFFFFFFFF, remainder = dividend;
    - DIV/REM with 0x80000000 / -1: quotient = 0x80000000, remainder = 0.
  - Otherwise the FSM runs with states IDLE, BUSY, DONE:
    - IDLE with a divide present: latch operand magnitudes and sign flags, StallE = 1, go to BUSY with count = 0.
    - BUSY: one restoring shift-subtract step per cycle, StallE = 1; after DIV_ITERS steps go to DONE.
    - DONE: apply sign fixup (quotient negative iff operand signs differ; remainder takes dividend sign). StallE = 0, the EX/MEM register captures the result, go to IDLE.
  - Total occupancy is 34 cycles in EX; StallE is high for 33 of them.
  - Operands are latched at start, because forwarded sources change while the pipeline drains bubbles.
  - DONE never restarts even though MulDivE is still high in that cycle.
- Reset mid-division: FSM goes to IDLE, StallE = 0 and the partial result is discarded.
- Back-to-back divides: the second divide starts in the cycle after DONE.

Optional Feature:
- Macro: EXEC_MDU_EN.
- Defined: the multiply/divide unit and FSM are present as described above.
- Undefined:
  - MulDivE and MulDivOpE are ignored;
  - the result is always the ALU result;
  - StallE is tied to 0;
  - no divider logic is instantiated.

Decomposition:
- Shared package riscv_pkg holds:
  - ALU op localparams;
  - MulDivOp encodings;
  - forwarding-select encodings;
  - the divider state enum (IDLE/BUSY/DONE).
- One sub-module, div_unit: the iterative divider FSM with start/busy/done handshake, sign handling and special-case bypass.

Test Plan:
- Forwarding: RD1_E = 5, ForwardAE = 10 with ALU_ResultM = 7; RD2_E = 3; add -> next ALU_ResultM = 10; then ForwardBE = 01 with ResultW = 9 -> WriteDataM = 9.
- Branch: PCE = 0x100, ImmExtE = 16, RD1 = RD2 = 4, BranchE = 1, sub -> PCSrcE = 1, PCTargetE = 0x110. With RD2 = 5 -> PCSrcE = 0.
- Multiply: MUL 6*7 -> 42, no stall; MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- Signed divide: DIV -7/2 -> StallE high exactly 33 cycles, RegWriteM = 0 during the stall, then ALU_ResultM = 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
- Divide special cases: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, each with StallE never asserted.
- Reset mid-division: rst low at BUSY iteration 10 -> StallE = 0 and all EX/MEM outputs 0. After release, DIVU 100/7 completes in 34 cycles with result 14.
